// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for the shared 4-bit ALU.
// Each operation is latched on acceptance. The ALU is driven from the latches
// for one cycle, and its result is captured. The result is then held on a
// valid/ready response channel, tagged with requester id and error flag.
module alu_arbiter #(
  parameter int OP_MAX = 12,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [3:0]       req0_op,
  input  logic [3:0]       req0_x,
  input  logic [3:0]       req0_y,
  input  logic [3:0]       req1_op,
  input  logic [3:0]       req1_x,
  input  logic [3:0]       req1_y,
  output logic [7:0]       alu_op,
  output logic [3:0]       alu_x,
  output logic [3:0]       alu_y,
  input  logic [7:0]       alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic             rsp_id,
  output logic             rsp_err,
  output logic [CNT_W-1:0] done_cnt,
  output logic [3:0]       err_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] OP_LIMIT = 4'(OP_MAX);

  state_t           state_q, state_d;
  logic             last_grant_q;
  logic [3:0]       op_q, x_q, y_q;
  logic             id_q, err_q;
  logic [7:0]       rsp_data_q;
  logic             rsp_id_q, rsp_err_q;
  logic [CNT_W-1:0] done_cnt_q;
  logic [3:0]       err_cnt_q;

  logic             gnt_id;
  logic             accept;
  logic             rsp_fire;
  logic [3:0]       sel_op, sel_x, sel_y;
  logic             sel_err;

  // Grant choice: a lone requester wins; on a tie, the requester not served last wins.
  always_comb begin
    gnt_id = 1'b0;
    if (req_valid == 2'b10) begin
      gnt_id = 1'b1;
    end else if (req_valid == 2'b11) begin
      gnt_id = ~last_grant_q;
    end
  end

  assign accept   = (state_q == IDLE) && (req_valid != 2'b00);
  assign rsp_fire = (state_q == RESP) && rsp_ready;

  // Mux the granted request and classify it as illegal or divide/modulo by zero.
  always_comb begin
    sel_op  = gnt_id ? req1_op : req0_op;
    sel_x   = gnt_id ? req1_x  : req0_x;
    sel_y   = gnt_id ? req1_y  : req0_y;
    sel_err = (sel_op > OP_LIMIT) ||
              (((sel_op == 4'd3) || (sel_op == 4'd10)) && (sel_y == 4'd0));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> EXEC on accept, EXEC -> RESP always, RESP -> IDLE on handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: the ready is one-hot to the granted requester in IDLE only; valid is asserted in RESP.
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 1'b0;
    if (accept) begin
      req_ready[gnt_id] = 1'b1;
    end
    if (state_q == RESP) begin
      rsp_valid = 1'b1;
    end
  end

  // Latch the accepted request; the latches keep driving the ALU between operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= 4'd0;
      x_q          <= 4'd0;
      y_q          <= 4'd0;
      id_q         <= 1'b0;
      err_q        <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (accept) begin
      op_q         <= sel_op;
      x_q          <= sel_x;
      y_q          <= sel_y;
      id_q         <= gnt_id;
      err_q        <= sel_err;
      last_grant_q <= gnt_id;
    end
  end

  // Capture the ALU result at the end of EXEC; errored operations return zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data_q <= 8'h00;
      rsp_id_q   <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else if (state_q == EXEC) begin
      rsp_data_q <= err_q ? 8'h00 : alu_result;
      rsp_id_q   <= id_q;
      rsp_err_q  <= err_q;
    end
  end

  // Count delivered responses (wrapping) and error responses (saturating at 15).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt_q <= '0;
      err_cnt_q  <= 4'd0;
    end else if (rsp_fire) begin
      done_cnt_q <= done_cnt_q + CNT_W'(1);
      if (rsp_err_q && (err_cnt_q != 4'd15)) begin
        err_cnt_q <= err_cnt_q + 4'd1;
      end
    end
  end

  assign alu_op   = {4'b0000, op_q};
  assign alu_x    = x_q;
  assign alu_y    = y_q;
  assign rsp_data = rsp_data_q;
  assign rsp_id   = rsp_id_q;
  assign rsp_err  = rsp_err_q;
  assign done_cnt = done_cnt_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter with a behavioural ALU and a response scoreboard.
module tb_alu_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [3:0] req0_op, req0_x, req0_y;
  logic [3:0] req1_op, req1_x, req1_y;
  logic [7:0] alu_op;
  logic [3:0] alu_x, alu_y;
  logic [7:0] alu_result;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_id;
  logic       rsp_err;
  logic [7:0] done_cnt;
  logic [3:0] err_cnt;

  typedef struct packed {
    logic [7:0] data;
    logic       id;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] m_done = 8'd0;
  logic [3:0] m_err  = 4'd0;
  logic       m_last = 1'b1;

  alu_arbiter #(.OP_MAX(12), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req0_op    (req0_op),
    .req0_x     (req0_x),
    .req0_y     (req0_y),
    .req1_op    (req1_op),
    .req1_x     (req1_x),
    .req1_y     (req1_y),
    .alu_op     (alu_op),
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_err    (rsp_err),
    .done_cnt   (done_cnt),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; divide/modulo by zero gives FF so masking by the arbiter is visible.
  function automatic logic [7:0] alu_model(input logic [3:0] op, input logic [3:0] x, input logic [3:0] y);
    logic [7:0] r;
    case (op)
      4'd0:    r = {4'b0, x} + {4'b0, y};
      4'd1:    r = {4'b0, x} - {4'b0, y};
      4'd2:    r = {4'b0, x} * {4'b0, y};
      4'd3:    r = (y == 4'd0) ? 8'hFF : {4'b0, x / y};
      4'd10:   r = (y == 4'd0) ? 8'hFF : {4'b0, x % y};
      default: r = {4'b0, x ^ y};
    endcase
    return r;
  endfunction

  function automatic logic err_model(input logic [3:0] op, input logic [3:0] y);
    return (op > 4'd12) || (((op == 4'd3) || (op == 4'd10)) && (y == 4'd0));
  endfunction

  assign alu_result = alu_model(alu_op[3:0], alu_x, alu_y);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one or two requests at a negedge, check the grant, push the expectation, then check EXEC.
  task automatic send(input logic v0, input logic [3:0] o0, input logic [3:0] x0, input logic [3:0] y0,
                      input logic v1, input logic [3:0] o1, input logic [3:0] x1, input logic [3:0] y1);
    logic       g;
    logic [3:0] op, x, y;
    exp_t       e;
    g = (v0 && v1) ? ~m_last : v1;
    req_valid = {v1, v0};
    req0_op = o0; req0_x = x0; req0_y = y0;
    req1_op = o1; req1_x = x1; req1_y = y1;
    #1;
    chk("grant", req_ready, g ? 2'b10 : 2'b01);
    op = g ? o1 : o0;
    x  = g ? x1 : x0;
    y  = g ? y1 : y0;
    e.err  = err_model(op, y);
    e.data = e.err ? 8'h00 : alu_model(op, x, y);
    e.id   = g;
    sb.push_back(e);
    m_last = g;
    @(posedge clk);
    @(negedge clk);
    req_valid[g] = 1'b0;
    #1;
    chk("exec_rsp_valid", rsp_valid, 1'b0);
    chk("exec_req_ready", req_ready, 2'b00);
    chk("exec_alu_op", alu_op, {4'b0, op});
    chk("exec_alu_x", alu_x, x);
    chk("exec_alu_y", alu_y, y);
    chk("exec_done_cnt", done_cnt, m_done);
  endtask

  // Expect a response on the next negedge, stall it, then complete the handshake.
  task automatic get_rsp(input int stall);
    exp_t e;
    @(negedge clk);
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      for (int k = 0; k <= stall; k++) begin
        rsp_ready = (k == stall);
        #1;
        chk("rsp_valid", rsp_valid, 1'b1);
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_err", rsp_err, e.err);
        chk("resp_req_ready", req_ready, 2'b00);
        chk("resp_done_cnt", done_cnt, m_done);
        if (k < stall) @(negedge clk);
      end
      @(posedge clk);
      m_done = m_done + 8'd1;
      if (e.err && m_err != 4'd15) m_err = m_err + 4'd1;
      @(negedge clk);
      rsp_ready = 1'b0;
      req_valid = 2'b00;
      #1;
      chk("post_rsp_valid", rsp_valid, 1'b0);
      chk("post_done_cnt", done_cnt, m_done);
      chk("post_err_cnt", err_cnt, m_err);
    end
  endtask

  task automatic check_reset_values();
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_rsp_id", rsp_id, 1'b0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_done_cnt", done_cnt, 8'h00);
    chk("rst_err_cnt", err_cnt, 4'h0);
    chk("rst_alu_op", alu_op, 8'h00);
    chk("rst_alu_x", alu_x, 4'h0);
    chk("rst_alu_y", alu_y, 4'h0);
  endtask

  task automatic model_reset();
    m_done = 8'd0;
    m_err  = 4'd0;
    m_last = 1'b1;
    sb.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    req0_op = 4'd0; req0_x = 4'd0; req0_y = 4'd0;
    req1_op = 4'd0; req1_x = 4'd0; req1_y = 4'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_values();
    chk("rst_req_ready_idle", req_ready, 2'b00);
    @(negedge clk);

    // Single operation, with rsp_ready held high outside RESP.
    rsp_ready = 1'b1;
    send(1'b1, 4'd0, 4'd5, 4'd3, 1'b0, 4'd0, 4'd0, 4'd0);
    get_rsp(0);
    chk("single_done_cnt", done_cnt, 8'd1);

    // Tie and round robin, both held valid; backpressure on the second response.
    send(1'b1, 4'd2, 4'd3, 4'd4, 1'b1, 4'd1, 4'd2, 4'd5);
    get_rsp(0);
    send(1'b1, 4'd2, 4'd3, 4'd4, 1'b1, 4'd1, 4'd2, 4'd5);
    get_rsp(5);
    send(1'b1, 4'd2, 4'd3, 4'd4, 1'b1, 4'd1, 4'd2, 4'd5);
    get_rsp(0);
    send(1'b1, 4'd2, 4'd3, 4'd4, 1'b1, 4'd1, 4'd2, 4'd5);
    get_rsp(2);

    // Sixteen error responses from requester 1; err_cnt saturates.
    for (int i = 0; i < 16; i++) begin
      case (i % 4)
        0:       send(1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 4'd3, 4'd9, 4'd0);
        1:       send(1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 4'd10, 4'd7, 4'd0);
        2:       send(1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 4'd13, 4'd2, 4'd2);
        default: send(1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 4'd15, 4'd1, 4'd6);
      endcase
      get_rsp(0);
    end
    chk("err_cnt_saturated", err_cnt, 4'd15);

    // Reset during EXEC drops the operation.
    send(1'b1, 4'd0, 4'd7, 4'd7, 1'b0, 4'd0, 4'd0, 4'd0);
    rst_n = 1'b0;
    #1;
    check_reset_values();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("inrst_rsp_valid", rsp_valid, 1'b0);
    end
    rst_n = 1'b1;
    model_reset();
    #1;
    check_reset_values();
    @(negedge clk);
    chk("postrst_rsp_valid", rsp_valid, 1'b0);
    send(1'b1, 4'd1, 4'd9, 4'd4, 1'b1, 4'd2, 4'd5, 4'd5);
    get_rsp(0);

    // 256 successful operations wrap done_cnt back to zero.
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      logic [3:0] op, x, y;
      op = 4'($urandom_range(0, 2));
      x  = 4'($urandom_range(0, 15));
      y  = 4'($urandom_range(0, 15));
      if ((i % 2) == 0) send(1'b1, op, x, y, 1'b0, 4'd0, 4'd0, 4'd0);
      else              send(1'b0, 4'd0, 4'd0, 4'd0, 1'b1, op, x, y);
      get_rsp(0);
    end
    chk("done_cnt_wrapped", done_cnt, 8'h00);
    chk("wrap_err_cnt", err_cnt, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared 4-bit ALU.
- Accepts operation requests (opcode, x, y) from two independent requesters over valid/ready handshakes.
- Grants the single combinational ALU round-robin and drives its opcode/operand inputs from registered state.
- Captures the ALU result and returns it, tagged with requester id and error flag, over a valid/ready response channel.
- Sits between the input-decoding front end and the ALU inside the Tiny Tapeout top.

## Interface
Parameters:
- OP_MAX, 12: highest legal ALU opcode; opcodes above it are errors.
- CNT_W, 8: width of completed-operation counter.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- req_valid  input  2  per-requester request valid (bit i = requester i)
- req_ready  output  2  per-requester accept; at most one bit high
- req0_op, req1_op  input  4 each  requested ALU opcode
- req0_x, req0_y, req1_x, req1_y  input  4 each  operands
- alu_op  output  8  to ALU opcode input, {4'b0, latched op}
- alu_x, alu_y  output  4 each  to ALU operands
- alu_result  input  8  combinational ALU output
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response accept from consumer
- rsp_data  output  8  captured result
- rsp_id  output  1  requester that issued the operation
- rsp_err  output  1  illegal opcode or divide/modulo by zero
- done_cnt  output  CNT_W  responses delivered, wrapping
- err_cnt  output  4  error responses delivered, saturating at 15

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready[i] high combinationally only for the granted requester.
  - Grant rule:
    - one valid requester: grant it;
    - both valid: grant the requester != last_grant;
    - none valid: req_ready = 0.
  - Handshake (valid & ready at clock edge):
    - latch op/x/y and id;
    - compute err = (op > OP_MAX) | ((op==3 | op==10) & y==0);
    - last_grant <= id;
    - go EXEC.
- EXEC:
  - alu_op/alu_x/alu_y driven from latched values (also driven from latches in other states; not zeroed).
  - On the edge:
    - rsp_data <= err ? 8'h00 : alu_result;
    - rsp_id, rsp_err loaded;
    - go RESP.
- RESP:
  - rsp_valid = 1; rsp_data/rsp_id/rsp_err stable until accepted.
  - req_ready = 0.
  - On rsp_valid & rsp_ready:
    - done_cnt +1 (wraps at 2^CNT_W-1 -> 0);
    - err_cnt +1 if rsp_err, holds at 15;
    - go IDLE.
- Arithmetic: no width manipulation in this block; ALU result passed through unchanged (subtraction results in two's complement, e.g. 2-5 = 8'hFD).
- Requester dropping req_valid while not granted: legal, no effect.
- Request held during another requester's operation: stays pending, wins next IDLE by round-robin.

## Timing
- Reset values: state IDLE; last_grant = 1 (requester 0 wins first tie); latched op/x/y = 0, so alu_op = 0, alu_x = 0, alu_y = 0; rsp_valid = 0; rsp_data = 0; rsp_id = 0; rsp_err = 0; done_cnt = 0; err_cnt = 0; req_ready follows IDLE rule.
- Latency:
  - accept at edge E0;
  - ALU driven during cycle E0..E1;
  - rsp_valid high after E1 (2 clocks);
  - earliest next accept is the edge after the response handshake.
- Peak throughput: 1 operation per 3 clocks.
- Backpressure: rsp_ready low holds RESP indefinitely, outputs frozen, no new accepts.
- Reset asserted in any state: immediate return to reset values; an in-flight operation is dropped with no response and no counter update.
- rsp_ready high outside RESP: ignored.

## Test plan
- Single op: after reset, req0 op=0 x=5 y=3 -> accepted first edge; rsp_valid two edges later; rsp_data=8'h08, rsp_id=0, rsp_err=0; done_cnt=1.
- Tie + round-robin:
  - stimulus: req0 op=2 x=3 y=4 and req1 op=1 x=2 y=5, both held valid;
  - first response 8'h0C id 0, then 8'hFD id 1;
  - then requeued req0 again; grants alternate 0,1,0,1.
- Errors:
  - req1 op=3 x=9 y=0 -> rsp_data=8'h00, rsp_err=1;
  - op=10 y=0 and op=13 -> rsp_err=1;
  - after 16 error responses err_cnt=15.
- Backpressure: rsp_ready low 5 cycles in RESP -> rsp_data/rsp_id stable, req_ready=2'b00 throughout, done_cnt unchanged until handshake.
- Reset mid-EXEC: assert rst_n=0 during EXEC -> rsp_valid never rises, all outputs at reset values; next request handled normally with req0 tie priority.
- Counter wrap: 256 successful ops -> done_cnt returns to 0.
